// File: rtl/ctrl_rep_pixel_pkg.sv
// ctrl_rep_pixel_pkg
// Shared definitions for the pixel-replication sequencer and anything else
// that needs to agree with it (datapath, VGA readout):
//   estado_t      sequencer state encoding
//   SEL_*         fator_sel codes
//   FW            width of the replication factor F (holds 1, 2 or 4)
//   decode_fator  fator_sel -> F
package ctrl_rep_pixel_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    LE      = 3'd1,
    CAPTURA = 3'd2,
    ESCREVE = 3'd3,
    FIM     = 3'd4
  } estado_t;

  localparam logic [1:0] SEL_X1       = 2'b00;
  localparam logic [1:0] SEL_X2       = 2'b01;
  localparam logic [1:0] SEL_X4       = 2'b10;
  localparam logic [1:0] SEL_INVALIDO = 2'b11;

  localparam int FW = 3;

  // The invalid code never reaches the counters (it is rejected in OCIOSO),
  // so mapping it to 1 only keeps the function total.
  function automatic logic [FW-1:0] decode_fator(input logic [1:0] sel);
    case (sel)
      SEL_X1:  return 3'd1;
      SEL_X2:  return 3'd2;
      SEL_X4:  return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_rep_pixel_gen_endereco.sv
// ctrl_rep_pixel_gen_endereco
// Source/destination address generator for pixel replication.
// Holds the source pixel counters (i row, j column) and the intra-block
// counters (ii row, jj column) and derives both RAM addresses from them.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   clr          zero all counters (start of a frame)
//   adv          step the block walk by one write (jj inner, ii outer)
//   fator        replication factor F, held stable for the whole frame
//   rd_addr      i*LARGURA + j
//   wr_addr      (i*F+ii)*(LARGURA*F) + (j*F+jj)
//   ult_bloco    current write is the last of the F x F block
//   ult_pixel    (i,j) is the last source pixel of the frame
module ctrl_rep_pixel_gen_endereco
  import ctrl_rep_pixel_pkg::*;
#(
  parameter int LARGURA = 160,
  parameter int ALTURA  = 120,
  parameter int RA_W    = 15,
  parameter int WA_W    = 19
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            adv,
  input  logic [FW-1:0]   fator,
  output logic [RA_W-1:0] rd_addr,
  output logic [WA_W-1:0] wr_addr,
  output logic            ult_bloco,
  output logic            ult_pixel
);

  localparam int IW = (ALTURA  > 1) ? $clog2(ALTURA)  : 1;
  localparam int JW = (LARGURA > 1) ? $clog2(LARGURA) : 1;

  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [FW-1:0] ii;
  logic [FW-1:0] jj;

  logic fim_linha;
  logic ult_coluna;

  assign fim_linha  = (jj == fator - FW'(1));
  assign ult_bloco  = fim_linha && (ii == fator - FW'(1));
  assign ult_coluna = (j == JW'(LARGURA - 1));
  assign ult_pixel  = ult_coluna && (i == IW'(ALTURA - 1));

  // Nested walk: jj fastest, then ii, then j across the row, then i.
  // After the very last pixel i wraps to 0 so the counters never leave range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i  <= '0;
      j  <= '0;
      ii <= '0;
      jj <= '0;
    end else if (clr) begin
      i  <= '0;
      j  <= '0;
      ii <= '0;
      jj <= '0;
    end else if (adv) begin
      if (!fim_linha) begin
        jj <= jj + FW'(1);
      end else begin
        jj <= '0;
        if (!ult_bloco) begin
          ii <= ii + FW'(1);
        end else begin
          ii <= '0;
          if (ult_coluna) begin
            j <= '0;
            i <= ult_pixel ? '0 : i + IW'(1);
          end else begin
            j <= j + JW'(1);
          end
        end
      end
    end
  end

  // All operands are widened before multiplying so no product is truncated
  // below the full destination address width.
  logic [WA_W-1:0] linha_dst;
  logic [WA_W-1:0] coluna_dst;

  always_comb begin
    linha_dst  = WA_W'(i) * WA_W'(fator) + WA_W'(ii);
    coluna_dst = WA_W'(j) * WA_W'(fator) + WA_W'(jj);
    wr_addr    = linha_dst * (WA_W'(LARGURA) * WA_W'(fator)) + coluna_dst;
    rd_addr    = RA_W'(i) * RA_W'(LARGURA) + RA_W'(j);
  end

endmodule

// File: rtl/ctrl_rep_pixel.sv
// ctrl_rep_pixel
// Sequencer for nearest-neighbour upscaling: reads each source pixel from a
// sync-read frame RAM and writes it as an F x F block into the destination
// frame RAM. F (1, 2 or 4) is latched when a frame starts.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   start        frame request, only looked at while idle
//   fator_sel    00=x1 01=x2 10=x4 11=invalid
//   cancela      synchronous abort of a running frame
//   busy         frame in progress (LE/CAPTURA/ESCREVE)
//   done         one-cycle pulse at the end of a complete frame
//   erro         one-cycle pulse after a start with the invalid code
//   rd_en/rd_addr/rd_data    source RAM port, data one cycle after rd_en
//   wr_en/wr_addr/wr_data    destination RAM write port
// Every output is a flop or a decode of registered state/counters.
module ctrl_rep_pixel
  import ctrl_rep_pixel_pkg::*;
#(
  parameter  int LARGURA   = 160,
  parameter  int ALTURA    = 120,
  parameter  int FATOR_MAX = 4,
  parameter  int DW        = 8,
  localparam int RA_W      = $clog2(LARGURA * ALTURA),
  localparam int WA_W      = $clog2(LARGURA * ALTURA * FATOR_MAX * FATOR_MAX)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      fator_sel,
  input  logic            cancela,
  output logic            busy,
  output logic            done,
  output logic            erro,
  output logic            rd_en,
  output logic [RA_W-1:0] rd_addr,
  input  logic [DW-1:0]   rd_data,
  output logic            wr_en,
  output logic [WA_W-1:0] wr_addr,
  output logic [DW-1:0]   wr_data
);

  estado_t       estado;
  estado_t       estado_prox;
  logic [FW-1:0] fator_reg;
  logic [DW-1:0] pixel_reg;
  logic          erro_reg;
  logic          aceita;
  logic          erro_prox;
  logic          ult_bloco;
  logic          ult_pixel;

  ctrl_rep_pixel_gen_endereco #(
    .LARGURA (LARGURA),
    .ALTURA  (ALTURA),
    .RA_W    (RA_W),
    .WA_W    (WA_W)
  ) u_gen_endereco (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (aceita),
    .adv       (estado == ESCREVE),
    .fator     (fator_reg),
    .rd_addr   (rd_addr),
    .wr_addr   (wr_addr),
    .ult_bloco (ult_bloco),
    .ult_pixel (ult_pixel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= OCIOSO;
      fator_reg <= 3'd1;
      pixel_reg <= '0;
      erro_reg  <= 1'b0;
    end else begin
      estado   <= estado_prox;
      erro_reg <= erro_prox;
      if (aceita) begin
        fator_reg <= decode_fator(fator_sel);
      end
      if (estado == CAPTURA) begin
        pixel_reg <= rd_data;
      end
    end
  end

  // Cancel overrides every transition out of a non-idle state, which also
  // makes it win over a start arriving in the same cycle.
  always_comb begin
    estado_prox = estado;
    aceita      = 1'b0;
    erro_prox   = 1'b0;
    case (estado)
      OCIOSO: begin
        if (start) begin
          if (fator_sel == SEL_INVALIDO) begin
            erro_prox = 1'b1;
          end else begin
            aceita      = 1'b1;
            estado_prox = LE;
          end
        end
      end
      LE:      estado_prox = CAPTURA;
      CAPTURA: estado_prox = ESCREVE;
      ESCREVE: begin
        if (ult_bloco) begin
          estado_prox = ult_pixel ? FIM : LE;
        end
      end
      FIM:     estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
    if (cancela && (estado != OCIOSO)) begin
      estado_prox = OCIOSO;
      aceita      = 1'b0;
    end
  end

  assign busy    = (estado == LE) || (estado == CAPTURA) || (estado == ESCREVE);
  assign done    = (estado == FIM);
  assign rd_en   = (estado == LE);
  assign wr_en   = (estado == ESCREVE);
  assign erro    = erro_reg;
  assign wr_data = pixel_reg;

endmodule

// File: tb/tb_ctrl_rep_pixel.sv
// tb_ctrl_rep_pixel
// Self-checking bench for ctrl_rep_pixel on a 4x3 source frame.
// A sync-read source RAM feeds the DUT; every destination write is logged and
// applied to a destination image, which is compared against the image and
// write order derived directly from the upscaling rules.
module tb_ctrl_rep_pixel;

  localparam int L    = 4;
  localparam int A    = 3;
  localparam int FM   = 4;
  localparam int DW   = 8;
  localparam int RA_W = 4;
  localparam int WA_W = 8;
  localparam int NPIX = L * A;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      fator_sel = 2'b00;
  logic            cancela = 1'b0;
  logic            busy;
  logic            done;
  logic            erro;
  logic            rd_en;
  logic [RA_W-1:0] rd_addr;
  logic [DW-1:0]   rd_data = '0;
  logic            wr_en;
  logic [WA_W-1:0] wr_addr;
  logic [DW-1:0]   wr_data;

  logic [24:0] saidas;
  assign saidas = {busy, done, erro, rd_en, wr_en, rd_addr, wr_addr, wr_data};

  ctrl_rep_pixel #(
    .LARGURA   (L),
    .ALTURA    (A),
    .FATOR_MAX (FM),
    .DW        (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .fator_sel (fator_sel),
    .cancela   (cancela),
    .busy      (busy),
    .done      (done),
    .erro      (erro),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] src [0:15];
  logic [DW-1:0] dst [0:255];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic done_busy = 1'b0;
  int erro_cnt = 0;
  int busy_cnt = 0;
  logic [WA_W-1:0] wq_addr [$];
  logic [DW-1:0]   wq_data [$];
  logic [RA_W-1:0] wq_rd   [$];

  // Sync-read source RAM: data appears the cycle after rd_en.
  always @(posedge clk) begin
    cyc++;
    if (rd_en) rd_data <= src[rd_addr];
  end

  // Monitor samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      wq_rd.push_back(rd_addr);
      dst[wr_addr] = wr_data;
    end
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = busy;
    end
    if (erro) erro_cnt++;
    if (busy) busy_cnt++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int fator_de(input logic [1:0] sel);
    return (sel == 2'b00) ? 1 : (sel == 2'b01) ? 2 : 4;
  endfunction

  // Reference write order: source pixels row-major, each as an F x F block
  // scanned row by row; the count of disagreeing entries is returned.
  function automatic int seq_errors(input int f);
    int n = 0;
    int k = 0;
    for (int i = 0; i < A; i++)
      for (int j = 0; j < L; j++)
        for (int ii = 0; ii < f; ii++)
          for (int jj = 0; jj < f; jj++) begin
            if (k >= wq_addr.size()) n++;
            else if (int'(wq_addr[k]) != (i * f + ii) * (L * f) + j * f + jj ||
                     wq_data[k] !== src[i * L + j]) n++;
            k++;
          end
    if (wq_addr.size() > k) n += wq_addr.size() - k;
    return n;
  endfunction

  // Reference image: destination pixel (r,c) is source pixel (r/F, c/F).
  function automatic int img_errors(input int f);
    int n = 0;
    for (int r = 0; r < A * f; r++)
      for (int c = 0; c < L * f; c++)
        if (dst[r * L * f + c] !== src[(r / f) * L + c / f]) n++;
    return n;
  endfunction

  function automatic int max_wr_addr();
    int m = -1;
    foreach (wq_addr[k]) if (int'(wq_addr[k]) > m) m = int'(wq_addr[k]);
    return m;
  endfunction

  task automatic clear_logs();
    wq_addr.delete();
    wq_data.delete();
    wq_rd.delete();
    for (int a = 0; a < 256; a++) dst[a] = 8'hEE;
  endtask

  task automatic fill_src(input bit aleatorio);
    for (int k = 0; k < 16; k++) src[k] = aleatorio ? 8'($urandom) : 8'(k);
  endtask

  task automatic pulse_start(input logic [1:0] sel, output int t0);
    @(negedge clk); #1;
    fator_sel = sel;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    fator_sel = 2'($urandom);
  endtask

  task automatic wait_done(input int d0, input int budget, output bit timeout);
    timeout = 1'b1;
    for (int k = 0; k < budget; k++) begin
      if (done_cnt != d0) begin
        timeout = 1'b0;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic run_frame(input logic [1:0] sel, output bit timeout, output int t0);
    int d0;
    clear_logs();
    d0 = done_cnt;
    pulse_start(sel, t0);
    wait_done(d0, 400, timeout);
  endtask

  task automatic test_reset();
    int d0;
    int nw;
    int t0;
    bit achou;
    @(negedge clk); @(negedge clk); #1;
    n_checks++;
    if (saidas !== 25'd0) $display("[TB] FAIL reset_initial: got %h, expected 0", saidas);
    else n_pass++;
    rst_n = 1'b1;
    fill_src(1'b0);
    clear_logs();
    d0 = done_cnt;
    pulse_start(2'b01, t0);
    achou = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (wq_addr.size() >= 6) begin
        achou = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    n_checks++;
    if (!achou || wr_en !== 1'b1 || wr_data !== 8'd1)
      $display("[TB] FAIL reach_escreve: got wr_en=%b wr_data=%h, expected 1 and 01", wr_en, wr_data);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (saidas !== 25'd0) $display("[TB] FAIL reset_async: got %h, expected 0", saidas);
    else n_pass++;
    @(negedge clk); @(negedge clk); #1;
    n_checks++;
    if (saidas !== 25'd0) $display("[TB] FAIL reset_held: got %h, expected 0", saidas);
    else n_pass++;
    nw = wq_addr.size();
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || wq_addr.size() != nw)
      $display("[TB] FAIL idle_after_reset: got busy=%b writes=%0d, expected 0 and %0d", busy, wq_addr.size(), nw);
    else n_pass++;
    n_checks++;
    if (done_cnt != d0) $display("[TB] FAIL no_done_on_reset: got %0d done, expected 0", done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_x2();
    bit to;
    int t0;
    fill_src(1'b0);
    run_frame(2'b01, to, t0);
    n_checks++;
    if (to) $display("[TB] FAIL x2_timeout: got no done, expected done");
    else n_pass++;
    n_checks++;
    if (wq_addr.size() != 48) $display("[TB] FAIL x2_write_count: got %0d, expected 48", wq_addr.size());
    else n_pass++;
    n_checks++;
    if (seq_errors(2) != 0) $display("[TB] FAIL x2_sequence: got %0d wrong writes, expected 0", seq_errors(2));
    else n_pass++;
    n_checks++;
    if ({dst[0], dst[1], dst[8], dst[9], dst[46], dst[47]} !== {8'h00, 8'h00, 8'h00, 8'h00, 8'h0B, 8'h0B})
      $display("[TB] FAIL x2_corners: got %h %h %h %h %h %h, expected 00 00 00 00 0b 0b",
               dst[0], dst[1], dst[8], dst[9], dst[46], dst[47]);
    else n_pass++;
    n_checks++;
    if (done_cyc - t0 != NPIX * 6 + 1) $display("[TB] FAIL x2_latency: got %0d, expected %0d", done_cyc - t0, NPIX * 6 + 1);
    else n_pass++;
    n_checks++;
    if (done_busy !== 1'b0) $display("[TB] FAIL x2_busy_at_done: got %b, expected 0", done_busy);
    else n_pass++;
  endtask

  task automatic test_x1();
    bit to;
    int t0;
    int nerr;
    fill_src(1'b0);
    run_frame(2'b00, to, t0);
    n_checks++;
    if (to || wq_addr.size() != 12) $display("[TB] FAIL x1_write_count: got %0d (timeout=%b), expected 12", wq_addr.size(), to);
    else n_pass++;
    nerr = 0;
    foreach (wq_addr[k]) if (wq_addr[k] !== WA_W'(wq_rd[k]) || wq_data[k] !== 8'(k) || int'(wq_addr[k]) != k) nerr++;
    n_checks++;
    if (nerr != 0) $display("[TB] FAIL x1_copy: got %0d bad writes, expected 0", nerr);
    else n_pass++;
    n_checks++;
    if (done_cyc - t0 != 37) $display("[TB] FAIL x1_latency: got %0d, expected 37", done_cyc - t0);
    else n_pass++;
  endtask

  task automatic test_x4();
    bit to;
    int t0;
    int nerr;
    fill_src(1'b0);
    run_frame(2'b10, to, t0);
    n_checks++;
    if (to || wq_addr.size() != 192) $display("[TB] FAIL x4_write_count: got %0d (timeout=%b), expected 192", wq_addr.size(), to);
    else n_pass++;
    nerr = 0;
    for (int r = 8; r < 12; r++)
      for (int c = 12; c < 16; c++)
        if (dst[r * 16 + c] !== 8'h0B) nerr++;
    n_checks++;
    if (nerr != 0) $display("[TB] FAIL x4_last_block: got %0d bad pixels, expected 0", nerr);
    else n_pass++;
    n_checks++;
    if (max_wr_addr() != 191) $display("[TB] FAIL x4_max_addr: got %0d, expected 191", max_wr_addr());
    else n_pass++;
    n_checks++;
    if (img_errors(4) != 0) $display("[TB] FAIL x4_image: got %0d bad pixels, expected 0", img_errors(4));
    else n_pass++;
    n_checks++;
    if (done_cyc - t0 != NPIX * 18 + 1) $display("[TB] FAIL x4_latency: got %0d, expected %0d", done_cyc - t0, NPIX * 18 + 1);
    else n_pass++;
  endtask

  task automatic test_erro_and_busy_start();
    int e0;
    int b0;
    int d0;
    int t0;
    int t1;
    bit to;
    bit achou;
    e0 = erro_cnt;
    b0 = busy_cnt;
    pulse_start(2'b11, t0);
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (erro_cnt - e0 != 1) $display("[TB] FAIL erro_pulse: got %0d cycles, expected 1", erro_cnt - e0);
    else n_pass++;
    n_checks++;
    if (busy_cnt != b0) $display("[TB] FAIL erro_no_busy: got %0d busy cycles, expected 0", busy_cnt - b0);
    else n_pass++;
    fill_src(1'b0);
    clear_logs();
    d0 = done_cnt;
    pulse_start(2'b01, t0);
    achou = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (wq_addr.size() >= 3) begin
        achou = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    pulse_start(2'b10, t1);
    wait_done(d0, 400, to);
    n_checks++;
    if (!achou || to) $display("[TB] FAIL busy_start_frame: got achou=%b timeout=%b, expected 1 0", achou, to);
    else n_pass++;
    n_checks++;
    if (seq_errors(2) != 0 || done_cyc - t0 != 73)
      $display("[TB] FAIL busy_start_ignored: got %0d bad writes latency %0d, expected 0 and 73", seq_errors(2), done_cyc - t0);
    else n_pass++;
    b0 = busy_cnt;
    repeat (10) @(negedge clk);
    #1;
    n_checks++;
    if (busy_cnt != b0 || erro_cnt - e0 != 1)
      $display("[TB] FAIL no_restart: got %0d busy cycles %0d erro, expected 0 and 1", busy_cnt - b0, erro_cnt - e0);
    else n_pass++;
  endtask

  task automatic test_cancela();
    int d0;
    int t0;
    bit achou;
    bit to;
    fill_src(1'b0);
    clear_logs();
    d0 = done_cnt;
    pulse_start(2'b01, t0);
    achou = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (wq_addr.size() >= 23) begin
        achou = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    cancela = 1'b1;
    start = 1'b1;
    @(negedge clk); #1;
    cancela = 1'b0;
    start = 1'b0;
    n_checks++;
    if (!achou || {busy, rd_en, wr_en} !== 3'b000)
      $display("[TB] FAIL cancel_idle: got busy,rd_en,wr_en=%b (reached=%b), expected 000", {busy, rd_en, wr_en}, achou);
    else n_pass++;
    repeat (10) @(negedge clk);
    #1;
    n_checks++;
    if (wq_addr.size() != 23 || done_cnt != d0)
      $display("[TB] FAIL cancel_stop: got %0d writes %0d done, expected 23 and 0", wq_addr.size(), done_cnt - d0);
    else n_pass++;
    run_frame(2'b01, to, t0);
    n_checks++;
    if (to || seq_errors(2) != 0 || img_errors(2) != 0 || done_cyc - t0 != 73)
      $display("[TB] FAIL after_cancel_frame: got timeout=%b bad=%0d latency=%0d, expected 0 0 73", to, seq_errors(2), done_cyc - t0);
    else n_pass++;
  endtask

  task automatic test_random_frames();
    logic [1:0] sel;
    bit to;
    int t0;
    int f;
    for (int n = 0; n < 4; n++) begin
      sel = 2'($urandom_range(0, 2));
      f = fator_de(sel);
      fill_src(1'b1);
      run_frame(sel, to, t0);
      n_checks++;
      if (to || seq_errors(f) != 0)
        $display("[TB] FAIL rand_sequence_%0d: got timeout=%b bad=%0d, expected 0 0 (F=%0d)", n, to, seq_errors(f), f);
      else n_pass++;
      n_checks++;
      if (img_errors(f) != 0) $display("[TB] FAIL rand_image_%0d: got %0d bad pixels, expected 0 (F=%0d)", n, img_errors(f), f);
      else n_pass++;
      n_checks++;
      if (done_cyc - t0 != NPIX * (2 + f * f) + 1)
        $display("[TB] FAIL rand_latency_%0d: got %0d, expected %0d", n, done_cyc - t0, NPIX * (2 + f * f) + 1);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_x2();
    test_x1();
    test_x4();
    test_erro_and_busy_start();
    test_cancela();
    test_random_frames();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
